calc_sequencer: RTL and testbench

//  Command side of the calculator Sel bus: turns keypad events into the 3-bit Sel

---
 rtl/calc_sequencer.sv | 115 +++++++++++
 tb/tb_calc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// Keypad-event to Sel-strobe sequencer for the calculator datapath; all outputs registered.
// Optional CALC_CHAIN_EN: an operator key in DONE copies the result into operand A.
module calc_sequencer #(
  parameter int ALU_LAT = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [1:0] key_type,
  input  logic [1:0] key_op,
  output logic [2:0] Sel,
  output logic [1:0] op_sel,
  output logic       busy,
  output logic       key_err
);

  typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, GOT_B, EXEC, DONE} state_t;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLEAR = 2'b11;

  localparam logic [2:0] SEL_NOP    = 3'b000;
  localparam logic [2:0] SEL_LOAD_A = 3'b001;
  localparam logic [2:0] SEL_LOAD_B = 3'b010;
  localparam logic [2:0] SEL_HOLD   = 3'b011;
  localparam logic [2:0] SEL_CLR    = 3'b100;
`ifdef CALC_CHAIN_EN
  localparam logic [2:0] SEL_COPY   = 3'b101;
`endif

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      Sel     <= SEL_NOP;
      op_sel  <= 2'b00;
      busy    <= 1'b0;
      key_err <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      Sel     <= SEL_NOP;
      key_err <= 1'b0;
      if (key_valid && key_type == K_CLEAR) begin
        Sel    <= SEL_CLR;
        op_sel <= 2'b00;
        busy   <= 1'b0;
        cnt    <= 4'd0;
        state  <= IDLE;
      end else if (state == EXEC) begin
        // The countdown runs regardless of keys; non-clear keys only flag an error.
        if (key_valid) key_err <= 1'b1;
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          Sel   <= SEL_HOLD;
          busy  <= 1'b0;
          state <= DONE;
        end
      end else if (key_valid) begin
        case (state)
          IDLE: begin
            if (key_type == K_DIGIT) begin
              Sel   <= SEL_LOAD_A;
              state <= GOT_A;
            end else key_err <= 1'b1;
          end
          GOT_A: begin
            if (key_type == K_DIGIT) Sel <= SEL_LOAD_A;
            else if (key_type == K_OP) begin
              op_sel <= key_op;
              state  <= GOT_OP;
            end else key_err <= 1'b1;
          end
          GOT_OP: begin
            if (key_type == K_DIGIT) begin
              Sel   <= SEL_LOAD_B;
              state <= GOT_B;
            end else if (key_type == K_OP) op_sel <= key_op;
            else key_err <= 1'b1;
          end
          GOT_B: begin
            if (key_type == K_DIGIT) Sel <= SEL_LOAD_B;
            else if (key_type == K_EQ) begin
              cnt   <= LAT_M1;
              busy  <= 1'b1;
              state <= EXEC;
            end else key_err <= 1'b1;
          end
          DONE: begin
            if (key_type == K_DIGIT) begin
              Sel   <= SEL_LOAD_A;
              state <= GOT_A;
            end
`ifdef CALC_CHAIN_EN
            else if (key_type == K_OP) begin
              op_sel <= key_op;
              Sel    <= SEL_COPY;
              state  <= GOT_OP;
            end
`endif
            else key_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed vector table, corner sequences, random vs model.
module tb_calc_sequencer;
  localparam int LAT = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_type = 2'b00;
  logic [1:0] key_op = 2'b00;
  logic [2:0] Sel;
  logic [1:0] op_sel;
  logic       busy;
  logic       key_err;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.ALU_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .key_valid(key_valid), .key_type(key_type),
    .key_op(key_op), .Sel(Sel), .op_sel(op_sel), .busy(busy), .key_err(key_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [1:0] t;
    logic [1:0] o;
    logic [2:0] sel;
    logic [1:0] ops;
    logic       bsy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [1:0] t, logic [1:0] o, logic [2:0] sel,
                              logic [1:0] ops, logic bsy, logic err);
    vec_t r;
    r.v = v; r.t = t; r.o = o; r.sel = sel; r.ops = ops; r.bsy = bsy; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] e_sel, input logic [1:0] e_op,
                           input logic e_busy, input logic e_err);
    chk({tag, ".Sel"}, 32'(Sel), 32'(e_sel));
    chk({tag, ".op_sel"}, 32'(op_sel), 32'(e_op));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".key_err"}, 32'(key_err), 32'(e_err));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [1:0] t, input logic [1:0] o);
    @(negedge clock);
    key_valid = v; key_type = t; key_op = o;
    @(posedge clock);
    #1;
  endtask

  // Reference model state: operand progress flags and absolute capture cycle.
  bit         m_a, m_opk, m_b, m_done, m_exec;
  int         m_cap, k;
  logic [1:0] m_op;

  initial begin
    // Reset state while reset_n is held low.
    #12;
    check_out("reset", 3'd0, 2'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b0, 2'd0, 2'd0);
    check_out("post_reset", 3'd0, 2'd0, 1'b0, 1'b0);

    vecs.push_back(mk(1, 2'd0, 2'd0, 3'd1, 2'd0, 0, 0)); // digit -> GOT_A
    vecs.push_back(mk(1, 2'd0, 2'd0, 3'd1, 2'd0, 0, 0)); // overwrite
    vecs.push_back(mk(1, 2'd2, 2'd0, 3'd0, 2'd0, 0, 1)); // equals in GOT_A
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    vecs.push_back(mk(1, 2'd1, 2'd2, 3'd0, 2'd2, 0, 0)); // op -> GOT_OP
    vecs.push_back(mk(1, 2'd1, 2'd1, 3'd0, 2'd1, 0, 0));
    vecs.push_back(mk(1, 2'd1, 2'd2, 3'd0, 2'd2, 0, 0));
    vecs.push_back(mk(1, 2'd0, 2'd0, 3'd2, 2'd2, 0, 0)); // digit -> GOT_B
    vecs.push_back(mk(1, 2'd1, 2'd3, 3'd0, 2'd2, 0, 1)); // op in GOT_B ignored
    vecs.push_back(mk(1, 2'd0, 2'd0, 3'd2, 2'd2, 0, 0));
    vecs.push_back(mk(1, 2'd2, 2'd0, 3'd0, 2'd2, 1, 0)); // equals at edge N
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd0, 2'd2, 1, 0));
    vecs.push_back(mk(1, 2'd0, 2'd0, 3'd0, 2'd2, 1, 1)); // digit in EXEC
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd0, 2'd2, 1, 0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd3, 2'd2, 0, 0)); // capture after edge N+4
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd0, 2'd2, 0, 0));
    vecs.push_back(mk(1, 2'd2, 2'd0, 3'd0, 2'd2, 0, 1)); // equals in DONE
`ifdef CALC_CHAIN_EN
    vecs.push_back(mk(1, 2'd1, 2'd3, 3'd5, 2'd3, 0, 0)); // chain copy
`else
    vecs.push_back(mk(1, 2'd1, 2'd3, 3'd0, 2'd2, 0, 1)); // op in DONE ignored
`endif
    vecs.push_back(mk(1, 2'd3, 2'd0, 3'd4, 2'd0, 0, 0)); // clear
    vecs.push_back(mk(0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    vecs.push_back(mk(1, 2'd2, 2'd0, 3'd0, 2'd0, 0, 1)); // equals in IDLE

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].t, vecs[i].o);
      check_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ops, vecs[i].bsy, vecs[i].err);
    end

    // Abort: clear on the second EXEC cycle, capture must never appear.
    step(1, 2'd0, 2'd0); check_out("abort.a", 3'd1, 2'd0, 0, 0);
    step(1, 2'd1, 2'd1); check_out("abort.op", 3'd0, 2'd1, 0, 0);
    step(1, 2'd0, 2'd0); check_out("abort.b", 3'd2, 2'd1, 0, 0);
    step(1, 2'd2, 2'd0); check_out("abort.eq", 3'd0, 2'd1, 1, 0);
    step(0, 2'd0, 2'd0); check_out("abort.x1", 3'd0, 2'd1, 1, 0);
    step(1, 2'd3, 2'd0); check_out("abort.clr", 3'd4, 2'd0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 2'd0, 2'd0);
      check_out($sformatf("abort.idle%0d", i), 3'd0, 2'd0, 0, 0);
    end

    // Asynchronous reset in the middle of EXEC.
    step(1, 2'd0, 2'd0);
    step(1, 2'd1, 2'd2);
    step(1, 2'd0, 2'd0);
    step(1, 2'd2, 2'd0);
    step(0, 2'd0, 2'd0); check_out("rst.pre", 3'd0, 2'd2, 1, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_out("rst.async", 3'd0, 2'd0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 2'd0);
      check_out($sformatf("rst.rel%0d", i), 3'd0, 2'd0, 0, 0);
    end
    step(1, 2'd1, 2'd3); check_out("rst.idle_op", 3'd0, 2'd0, 0, 1);

    // Random keys against the reference model; first step is a forced clear to align.
    m_a = 0; m_opk = 0; m_b = 0; m_done = 0; m_exec = 0; m_cap = 0; m_op = 2'd0; k = 0;
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [1:0] t, o;
      logic [2:0] e_sel;
      logic       e_err;
      int         r;
      r = int'($urandom_range(15));
      v = ($urandom_range(9) < 7);
      t = (r == 0) ? 2'd3 : (r < 8) ? 2'd0 : (r < 12) ? 2'd1 : 2'd2;
      o = 2'($urandom_range(3));
      if (i == 0) begin v = 1'b1; t = 2'd3; end
      k++;
      e_sel = 3'd0; e_err = 1'b0;
      if (v && t == 2'd3) begin
        e_sel = 3'd4; m_op = 2'd0;
        m_a = 0; m_opk = 0; m_b = 0; m_done = 0; m_exec = 0;
      end else if (m_exec) begin
        if (v) e_err = 1'b1;
        if (k == m_cap) begin
          e_sel = 3'd3; m_exec = 0; m_done = 1;
        end
      end else if (v) begin
        case (t)
          2'd0: begin
            if (m_opk) begin e_sel = 3'd2; m_b = 1; end
            else begin e_sel = 3'd1; m_a = 1; m_done = 0; end
          end
          2'd1: begin
            if (m_a && !m_b) begin m_op = o; m_opk = 1; end
`ifdef CALC_CHAIN_EN
            else if (m_done) begin
              m_op = o; e_sel = 3'd5; m_done = 0; m_a = 1; m_opk = 1;
            end
`endif
            else e_err = 1'b1;
          end
          default: begin
            if (m_b) begin
              m_exec = 1; m_cap = k + LAT; m_a = 0; m_opk = 0; m_b = 0;
            end else e_err = 1'b1;
          end
        endcase
      end
      step(v, t, o);
      check_out($sformatf("rnd%0d", i), e_sel, m_op, m_exec, e_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
